// File: rtl/simplerisc_pkg.sv
// SimpleRISC shared definitions: opcodes, fixed encodings and the
// instruction field helpers used by the OF/EX latch and the forwarding units.
package simplerisc_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    localparam logic [31:0] NOP_IR = 32'h6800_0000;
    localparam logic [3:0]  RA_REG = 4'hF;

    function automatic logic [4:0] opcode_of(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    function automatic logic [3:0] rd_of(input logic [31:0] ir);
        return ir[25:22];
    endfunction

    // ret reads the return address register instead of rs1
    function automatic logic [3:0] src1_of(input logic [31:0] ir);
        return (ir[31:27] == OP_RET) ? RA_REG : ir[21:18];
    endfunction

    // st reads its data register through the rd field
    function automatic logic [3:0] src2_of(input logic [31:0] ir);
        return (ir[31:27] == OP_ST) ? ir[25:22] : ir[17:14];
    endfunction

    function automatic logic uses_src1(input logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        return !(op inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_NOT, OP_MOV});
    endfunction

    function automatic logic uses_src2(input logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        return (op == OP_ST) || ((op <= OP_ASR) && !ir[26]);
    endfunction

endpackage

// File: rtl/of_ex_latch_if.sv
// OF/EX latch bus: operand-fetch side inputs, EX side outputs and the
// stall/flush/hold control. master = surrounding pipeline, slave = latch.
interface of_ex_latch_if #(
    parameter int XLEN = 32
);
    logic            of_valid;
    logic [31:0]     of_pc;
    logic [31:0]     of_ir;
    logic [XLEN-1:0] of_op1;
    logic [XLEN-1:0] of_op2;
    logic [XLEN-1:0] rw_result;
    logic            fwd_rw_of_src1;
    logic            fwd_rw_of_src2;
    logic            branch_taken;
    logic            pipe_hold;

    logic            ex_valid;
    logic [31:0]     ex_pc;
    logic [31:0]     ex_ir;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_op2;
    logic            stall_out;
    logic [31:0]     stall_cnt;

    modport master (
        output of_valid, of_pc, of_ir, of_op1, of_op2, rw_result,
               fwd_rw_of_src1, fwd_rw_of_src2, branch_taken, pipe_hold,
        input  ex_valid, ex_pc, ex_ir, ex_a, ex_b, ex_op2, stall_out, stall_cnt
    );

    modport slave (
        input  of_valid, of_pc, of_ir, of_op1, of_op2, rw_result,
               fwd_rw_of_src1, fwd_rw_of_src2, branch_taken, pipe_hold,
        output ex_valid, ex_pc, ex_ir, ex_a, ex_b, ex_op2, stall_out, stall_cnt
    );
endinterface

// File: rtl/imm_extend.sv
// Immediate builder: 16-bit imm plus 2-bit modifier to an XLEN operand.
// 00/11 sign-extend, 01 zero-extend, 10 place imm in the upper half.
module imm_extend #(
    parameter int XLEN = 32
) (
    input  logic [17:0]     imm_mod_i,
    output logic [XLEN-1:0] immx_o
);
    logic [15:0] imm;
    logic [1:0]  modifier;

    assign imm      = imm_mod_i[15:0];
    assign modifier = imm_mod_i[17:16];

    // select extension form from the modifier
    always_comb begin
        immx_o = {{(XLEN-16){imm[15]}}, imm};
        case (modifier)
            2'b01:   immx_o = {{(XLEN-16){1'b0}}, imm};
            2'b10:   immx_o = XLEN'({imm, 16'h0000});
            default: immx_o = {{(XLEN-16){imm[15]}}, imm};
        endcase
    end
endmodule

// File: rtl/of_ex_latch.sv
// OF/EX pipeline register of the SimpleRISC core. Applies RW->OF operand
// forwarding, builds the immediate, detects the load-use interlock and
// handles flush (branch_taken) and freeze (pipe_hold).
// Optional: define OF_EX_STALL_CNT_EN for the bubble/flush counter.
module of_ex_latch
    import simplerisc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    of_ex_latch_if.slave  bus
);
    logic            ex_valid_q, ex_valid_d;
    logic [31:0]     ex_pc_q,    ex_pc_d;
    logic [31:0]     ex_ir_q,    ex_ir_d;
    logic [XLEN-1:0] ex_a_q,     ex_a_d;
    logic [XLEN-1:0] ex_b_q,     ex_b_d;
    logic [XLEN-1:0] ex_op2_q,   ex_op2_d;

    logic [XLEN-1:0] op1f, op2f, immx;
    logic            dep_src1, dep_src2, interlock;

    imm_extend #(.XLEN(XLEN)) u_imm (
        .imm_mod_i (bus.of_ir[17:0]),
        .immx_o    (immx)
    );

    assign op1f = bus.fwd_rw_of_src1 ? bus.rw_result : bus.of_op1;
    assign op2f = bus.fwd_rw_of_src2 ? bus.rw_result : bus.of_op2;

    // a load in EX cannot forward to OF yet; a dependent OF instruction waits one cycle
    assign dep_src1  = uses_src1(bus.of_ir) && (src1_of(bus.of_ir) == rd_of(ex_ir_q));
    assign dep_src2  = uses_src2(bus.of_ir) && (src2_of(bus.of_ir) == rd_of(ex_ir_q));
    assign interlock = ex_valid_q && (opcode_of(ex_ir_q) == OP_LD) && bus.of_valid
                       && (dep_src1 || dep_src2);

    // wrong-path OF (flush) or frozen pipe never stalls the front end
    assign bus.stall_out = interlock && !bus.branch_taken && !bus.pipe_hold;

    // next EX contents: hold keeps, flush/interlock bubble, otherwise advance OF
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_ir_d    = ex_ir_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_op2_d   = ex_op2_q;
        if (!bus.pipe_hold) begin
            if (bus.branch_taken || interlock) begin
                ex_valid_d = 1'b0;
                ex_pc_d    = '0;
                ex_ir_d    = NOP_IR;
                ex_a_d     = '0;
                ex_b_d     = '0;
                ex_op2_d   = '0;
            end else begin
                ex_valid_d = bus.of_valid;
                ex_pc_d    = bus.of_pc;
                ex_ir_d    = bus.of_ir;
                ex_a_d     = op1f;
                ex_b_d     = bus.of_ir[26] ? immx : op2f;
                ex_op2_d   = op2f;
            end
        end
    end

    // EX register bank, reset loads a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_ir_q    <= NOP_IR;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_op2_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_ir_q    <= ex_ir_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_op2_q   <= ex_op2_d;
        end
    end

    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_pc    = ex_pc_q;
    assign bus.ex_ir    = ex_ir_q;
    assign bus.ex_a     = ex_a_q;
    assign bus.ex_b     = ex_b_q;
    assign bus.ex_op2   = ex_op2_q;

`ifdef OF_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = stall_cnt_q + 32'd1;

    // count every bubble inserted by flush or interlock; frozen edges do not count
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (!bus.pipe_hold && (bus.branch_taken || interlock))
            stall_cnt_q <= stall_cnt_d;
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_of_ex_latch.sv
// Bench for of_ex_latch: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the EX stage.
module tb_of_ex_latch;
`ifdef OF_EX_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    of_ex_latch_if #(.XLEN(32)) bus ();

    of_ex_latch #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural model ----------------
    bit          m_ok = 1'b0;
    bit          m_valid;
    logic [31:0] m_pc, m_ir, m_a, m_b, m_op2, m_cnt;

    function automatic bit reads_reg(input logic [31:0] ir, input logic [3:0] r);
        int op;
        int s1, s2;
        bit r1, r2;
        op = int'(ir[31:27]);
        s1 = (op == 20) ? 15 : int'(ir[21:18]);
        s2 = (op == 15) ? int'(ir[25:22]) : int'(ir[17:14]);
        r1 = !(op == 13 || op == 18 || op == 16 || op == 17 || op == 19 || op == 8 || op == 9);
        r2 = (op == 15) || (op <= 12 && ir[26] == 1'b0);
        return (r1 && s1 == int'(r)) || (r2 && s2 == int'(r));
    endfunction

    function automatic bit m_hazard();
        return m_valid && (m_ir[31:27] == 5'd14) && bus.of_valid
               && reads_reg(bus.of_ir, m_ir[25:22]);
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] ir);
        int unsigned imm;
        imm = ir[15:0];
        case (ir[17:16])
            2'd1:    return imm;
            2'd2:    return imm * 65536;
            default: return (imm < 32768) ? imm : imm + 32'hFFFF_0000;
        endcase
    endfunction

    task automatic m_bubble();
        m_valid = 1'b0; m_pc = 0; m_ir = 32'h6800_0000; m_a = 0; m_b = 0; m_op2 = 0;
    endtask

    always @(posedge clk) begin
        logic [31:0] a, o2;
        bit hz;
        hz = m_ok && m_hazard();
        if (rst) begin
            m_bubble();
            m_cnt = 0;
            m_ok  = 1'b1;
        end else if (!m_ok || bus.pipe_hold) begin
            // frozen
        end else if (bus.branch_taken || hz) begin
            m_bubble();
            m_cnt = m_cnt + 1;
        end else begin
            a  = bus.fwd_rw_of_src1 ? bus.rw_result : bus.of_op1;
            o2 = bus.fwd_rw_of_src2 ? bus.rw_result : bus.of_op2;
            m_valid = bus.of_valid;
            m_pc    = bus.of_pc;
            m_ir    = bus.of_ir;
            m_a     = a;
            m_op2   = o2;
            m_b     = bus.of_ir[26] ? m_imm(bus.of_ir) : o2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cexp(input logic [31:0] n);
        return CNT_EN ? n : 32'd0;
    endfunction

    // compare process: every cycle after the first reset edge
    always @(negedge clk) begin
        if (m_ok) begin
            chk("ex_valid",  32'(bus.ex_valid), 32'(m_valid));
            chk("ex_pc",     bus.ex_pc,  m_pc);
            chk("ex_ir",     bus.ex_ir,  m_ir);
            chk("ex_a",      bus.ex_a,   m_a);
            chk("ex_b",      bus.ex_b,   m_b);
            chk("ex_op2",    bus.ex_op2, m_op2);
            chk("stall_out", 32'(bus.stall_out),
                32'(m_hazard() && !bus.branch_taken && !bus.pipe_hold));
            chk("stall_cnt", bus.stall_cnt, cexp(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                         input logic [31:0] o1, input logic [31:0] o2);
        bus.of_valid = v; bus.of_pc = pc; bus.of_ir = ir;
        bus.of_op1 = o1; bus.of_op2 = o2;
    endtask

    localparam logic [31:0] NOP    = 32'h6800_0000;
    localparam logic [31:0] ADD312 = 32'h00C4_8000; // add r3,r1,r2
    localparam logic [31:0] ADDI0  = 32'h04C4_FFFF; // addi r3,r1,0xFFFF mod 00
    localparam logic [31:0] ADDI2  = 32'h04C6_FFFF; // same, mod 10
    localparam logic [31:0] LD4    = 32'h7504_0000; // ld r4,0[r1]
    localparam logic [31:0] ADD546 = 32'h0151_8000; // add r5,r4,r6

    initial begin
        rst = 1'b1;
        drive(1'b0, 0, 0, 0, 0);
        bus.rw_result = 0; bus.fwd_rw_of_src1 = 0; bus.fwd_rw_of_src2 = 0;
        bus.branch_taken = 0; bus.pipe_hold = 0;
        step(); step();
        rst = 1'b0;
        chk("rst_ir",    bus.ex_ir, NOP);
        chk("rst_valid", 32'(bus.ex_valid), 0);
        chk("rst_stall", 32'(bus.stall_out), 0);

        drive(1'b1, 32'h100, ADD312, 5, 7);
        step();
        chk("add_a", bus.ex_a, 5);
        chk("add_b", bus.ex_b, 7);
        chk("add_valid", 32'(bus.ex_valid), 1);

        drive(1'b1, 32'h104, ADDI0, 1, 0);
        bus.rw_result = 32'hAAAA; bus.fwd_rw_of_src1 = 1;
        step();
        chk("fwd_a", bus.ex_a, 32'hAAAA);
        chk("imm_sext", bus.ex_b, 32'hFFFF_FFFF);
        bus.fwd_rw_of_src1 = 0;
        drive(1'b1, 32'h108, ADDI2, 1, 0);
        step();
        chk("imm_hi", bus.ex_b, 32'hFFFF_0000);

        // load-use interlock
        drive(1'b1, 32'h10C, LD4, 0, 0);
        step();
        drive(1'b1, 32'h110, ADD546, 0, 0);
        #1 chk("lu_stall", 32'(bus.stall_out), 1);
        step();
        chk("lu_bubble", bus.ex_ir, NOP);
        chk("lu_cnt", bus.stall_cnt, cexp(1));
        #1 chk("lu_release", 32'(bus.stall_out), 0);

        // interlock + flush
        drive(1'b1, 32'h10C, LD4, 0, 0);
        step();
        drive(1'b1, 32'h110, ADD546, 0, 0);
        bus.branch_taken = 1;
        #1 chk("fl_stall", 32'(bus.stall_out), 0);
        step();
        bus.branch_taken = 0;
        chk("fl_bubble", bus.ex_ir, NOP);
        chk("fl_cnt", bus.stall_cnt, cexp(2));

        // interlock under hold
        drive(1'b1, 32'h10C, LD4, 0, 0);
        step();
        drive(1'b1, 32'h110, ADD546, 0, 0);
        bus.pipe_hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hd_stall", 32'(bus.stall_out), 0);
            step();
            chk("hd_ir", bus.ex_ir, LD4);
            chk("hd_cnt", bus.stall_cnt, cexp(2));
        end
        bus.pipe_hold = 0;
        #1 chk("hd_rel_stall", 32'(bus.stall_out), 1);
        step();
        chk("hd_bubble", bus.ex_ir, NOP);
        chk("hd_rel_cnt", bus.stall_cnt, cexp(3));

        // reset during a pending interlock
        drive(1'b1, 32'h10C, LD4, 0, 0);
        step();
        drive(1'b1, 32'h110, ADD546, 0, 0);
        rst = 1;
        step();
        rst = 0;
        chk("rs_ir", bus.ex_ir, NOP);
        chk("rs_cnt", bus.stall_cnt, 0);
        #1 chk("rs_stall", 32'(bus.stall_out), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  op;
            logic [3:0]  rd, r1, r2;
            op = ($urandom_range(3) == 0) ? 5'd14 : 5'($urandom_range(20));
            rd = ($urandom_range(15) == 0) ? 4'hF : 4'($urandom_range(3));
            r1 = ($urandom_range(15) == 0) ? 4'hF : 4'($urandom_range(3));
            r2 = 4'($urandom_range(3));
            drive($urandom_range(7) != 0, $urandom,
                  {op, 1'($urandom), rd, r1, r2, 14'($urandom)}, $urandom, $urandom);
            bus.rw_result      = $urandom;
            bus.fwd_rw_of_src1 = 1'($urandom);
            bus.fwd_rw_of_src2 = 1'($urandom);
            bus.branch_taken   = ($urandom_range(9) == 0);
            bus.pipe_hold      = ($urandom_range(6) == 0);
            rst                = ($urandom_range(199) == 0);
            step();
        end
        rst = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
